// File: rtl/mod_memstage.sv
// mod_memstage: memory-access stage between regread and execute.
// Loads fill the 8-byte load buffer, stores drive the bus with byte
// enables; accesses crossing an 8-byte boundary take two aligned beats.
// Optional feature: define MEMSTAGE_STLD_FWD_EN to serve an unsplit load
// that exactly matches the last completed store (same addr and size)
// straight from a one-entry store buffer, without touching the bus.
module mod_memstage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [1:0]        in_size,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [31:0]       in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_tag,
  output logic [DATA_W-1:0] load_buffer,
  output logic              loadbuffer_done,
  output logic              memstage_active,
  output logic              store_memstage_active,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE
  } state_e;

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;

  state_e            state_q;
  logic [1:0]        kind_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] beat0_q;
  logic [DATA_W-1:0] loadBuf_q;
  logic [31:0]       tag_q;

  logic [2:0]        off;
  logic [5:0]        shamt;
  logic [3:0]        nBytes;
  logic [15:0]       laneSpan;
  logic              needBeat1;
  logic [127:0]      rotDbl;
  logic [63:0]       rotData;
  logic [127:0]      mergeSrc;
  logic [127:0]      mergeShift;
  logic [63:0]       merged;
  logic [1:0]        kindIn;
  logic              fwdHit;
  logic [63:0]       fwdData;

  // Zero-extension mask covering the low (1<<size) bytes.
  function automatic logic [63:0] sizeMask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Lane geometry of the captured op: which lanes each beat touches, the
  // store data rotated into lane position, and the merged load result.
  always_comb begin
    off        = addr_q[2:0];
    shamt      = {off, 3'b000};
    nBytes     = 4'd1 << size_q;
    laneSpan   = ((16'd1 << nBytes) - 16'd1) << off;
    needBeat1  = |laneSpan[15:8];
    rotDbl     = {wdata_q, wdata_q} << shamt;
    rotData    = rotDbl[127:64];
    mergeSrc   = (state_q == S_WAIT1) ? {mem_resp_rdata, beat0_q} : {64'd0, mem_resp_rdata};
    mergeShift = mergeSrc >> shamt;
    merged     = mergeShift[63:0] & sizeMask(size_q);
    kindIn     = (in_kind == KIND_LOAD || in_kind == KIND_STORE) ? in_kind : KIND_NONE;
  end

`ifdef MEMSTAGE_STLD_FWD_EN
  logic              fwdValid_q;
  logic [ADDR_W-1:0] fwdAddr_q;
  logic [1:0]        fwdSize_q;
  logic [63:0]       fwdData_q;
  logic [3:0]        inEnd;

  // An incoming load hits when it is unsplit and matches the saved store exactly.
  always_comb begin
    inEnd   = {1'b0, in_addr[2:0]} + (4'd1 << in_size);
    fwdHit  = fwdValid_q && (kindIn == KIND_LOAD) && (inEnd <= 4'd8) &&
              (in_addr == fwdAddr_q) && (in_size == fwdSize_q);
    fwdData = fwdData_q;
  end

  // Remember the most recent store once it has been handed to execute.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwdValid_q <= 1'b0;
      fwdAddr_q  <= '0;
      fwdSize_q  <= 2'd0;
      fwdData_q  <= 64'd0;
    end else if (state_q == S_DONE && out_ready && kind_q == KIND_STORE) begin
      fwdValid_q <= 1'b1;
      fwdAddr_q  <= addr_q;
      fwdSize_q  <= size_q;
      fwdData_q  <= wdata_q & sizeMask(size_q);
    end
  end
`else
  assign fwdHit  = 1'b0;
  assign fwdData = 64'd0;
`endif

  // Main sequencer: capture at accept, issue one or two beats, merge, hand off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      kind_q    <= KIND_NONE;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tag_q     <= 32'd0;
      beat0_q   <= '0;
      loadBuf_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            kind_q  <= kindIn;
            size_q  <= in_size;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            tag_q   <= in_tag;
            if (kindIn == KIND_NONE) begin
              state_q <= S_DONE;
            end else if (fwdHit) begin
              loadBuf_q <= fwdData;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_REQ0;
            end
          end
        end
        S_REQ0: if (mem_req_ready) state_q <= S_WAIT0;
        S_WAIT0: begin
          if (mem_resp_valid) begin
            if (needBeat1) begin
              beat0_q <= mem_resp_rdata;
              state_q <= S_REQ1;
            end else begin
              if (kind_q == KIND_LOAD) loadBuf_q <= merged;
              state_q <= S_DONE;
            end
          end
        end
        S_REQ1: if (mem_req_ready) state_q <= S_WAIT1;
        S_WAIT1: begin
          if (mem_resp_valid) begin
            if (kind_q == KIND_LOAD) loadBuf_q <= merged;
            state_q <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready              = (state_q == S_IDLE);
  assign out_valid             = (state_q == S_DONE);
  assign out_tag               = tag_q;
  assign load_buffer           = loadBuf_q;
  assign loadbuffer_done       = out_valid && (kind_q == KIND_LOAD);
  assign memstage_active       = (state_q != S_IDLE);
  assign store_memstage_active = memstage_active && (kind_q == KIND_STORE);

  assign mem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign mem_req_we    = mem_req_valid && (kind_q == KIND_STORE);
  assign mem_req_addr  = mem_req_valid ?
                         ({addr_q[ADDR_W-1:3], 3'b000} + ((state_q == S_REQ1) ? ADDR_W'(8) : '0)) : '0;
  assign mem_req_wdata = mem_req_we ? rotData : '0;
  assign mem_req_wmask = mem_req_we ? ((state_q == S_REQ1) ? laneSpan[15:8] : laneSpan[7:0]) : 8'd0;

endmodule

// File: tb/tb_mod_memstage.sv
// tb_mod_memstage: scoreboard bench for mod_memstage with a small bus
// responder and an output monitor running on the falling clock edge.
module tb_mod_memstage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [1:0]  in_size;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_tag;
  logic [63:0] load_buffer;
  logic        loadbuffer_done;
  logic        memstage_active;
  logic        store_memstage_active;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  typedef struct {
    logic [31:0] tag;
    logic        isLoad;
    logic        isStore;
    logic [63:0] loadData;
  } outExp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } reqExp_t;

  outExp_t     expOut[$];
  reqExp_t     expReq[$];
  logic [63:0] respQ[$];

  int          checks = 0;
  int          errors = 0;
  int          memStall = 0;
  int          outStall = 0;
  int          reqHandshakes = 0;
  logic        injectResp = 1'b0;
  logic        pendingResp = 1'b0;
  logic [63:0] pendingData = 64'd0;

  mod_memstage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_kind               (in_kind),
    .in_size               (in_size),
    .in_addr               (in_addr),
    .in_wdata              (in_wdata),
    .in_tag                (in_tag),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_tag               (out_tag),
    .load_buffer           (load_buffer),
    .loadbuffer_done       (loadbuffer_done),
    .memstage_active       (memstage_active),
    .store_memstage_active (store_memstage_active),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_req_we            (mem_req_we),
    .mem_req_addr          (mem_req_addr),
    .mem_req_wdata         (mem_req_wdata),
    .mem_req_wmask         (mem_req_wmask),
    .mem_resp_valid        (mem_resp_valid),
    .mem_resp_rdata        (mem_resp_rdata)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] laneBits(input logic [7:0] m);
    logic [63:0] r;
    r = 64'd0;
    for (int k = 0; k < 8; k++) if (m[k]) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushReq(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask);
    reqExp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
    expReq.push_back(e);
  endtask

  task automatic pushOut(input logic [31:0] tag, input logic isLoad, input logic isStore, input logic [63:0] data);
    outExp_t e;
    e.tag = tag; e.isLoad = isLoad; e.isStore = isStore; e.loadData = data;
    expOut.push_back(e);
  endtask

  // Presents one op, holding in_valid for exactly the accepting cycle; returns on the falling edge after accept.
  task automatic applyStimulus(input logic [1:0] kind, input logic [1:0] size, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [31:0] tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout actual=busy required=in_ready tag=0x%0h", tag);
    end
    in_valid = 1'b1; in_kind = kind; in_size = size; in_addr = addr; in_wdata = wdata; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int w;
    w = 0;
    while ((expOut.size() != 0 || expReq.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL %s_drain actual=outQ%0d/reqQ%0d required=0/0", name, expOut.size(), expReq.size());
    end
  endtask

  // Bus responder: optional ready stalls, checks every request cycle against the
  // expected queue, and answers an accepted beat in the following cycle.
  initial begin
    reqExp_t e;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'd0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pendingResp) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pendingData;
        pendingResp    = 1'b0;
      end else if (injectResp) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        injectResp     = 1'b0;
      end
      if (mem_req_valid && memStall > 0) begin
        mem_req_ready = 1'b0;
        memStall--;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid) begin
        if (expReq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_req actual=0x%0h required=none", mem_req_addr);
        end else begin
          e = expReq[0];
          checkOutput("req_we", 64'(mem_req_we), 64'(e.we));
          checkOutput("req_addr", mem_req_addr, e.addr);
          if (e.we) begin
            checkOutput("req_wmask", 64'(mem_req_wmask), 64'(e.wmask));
            checkOutput("req_wdata", mem_req_wdata & laneBits(e.wmask), e.wdata);
          end
          if (mem_req_ready && reset_n) begin
            void'(expReq.pop_front());
            reqHandshakes++;
            if (respQ.size() > 0) begin
              pendingResp = 1'b1;
              pendingData = respQ.pop_front();
            end
          end
        end
      end
    end
  end

  // Output monitor: applies out_ready stalls and compares every valid cycle with the scoreboard head.
  initial begin
    outExp_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid && outStall > 0) begin
        out_ready = 1'b0;
        outStall--;
      end else begin
        out_ready = 1'b1;
      end
      if (memstage_active) begin
        if (expOut.size() > 0) checkOutput("store_active", 64'(store_memstage_active), 64'(expOut[0].isStore));
      end else begin
        checkOutput("store_idle", 64'(store_memstage_active), 64'd0);
      end
      if (out_valid) begin
        if (expOut.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_out actual=0x%0h required=none", out_tag);
        end else begin
          e = expOut[0];
          checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
          checkOutput("lb_done", 64'(loadbuffer_done), 64'(e.isLoad));
          if (e.isLoad) checkOutput("load_buffer", load_buffer, e.loadData);
          if (out_ready) void'(expOut.pop_front());
        end
      end
    end
  end

  // Guard against a hung handshake anywhere in the run.
  initial begin
    repeat (5000) @(posedge clk);
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int hsBefore;
    int w;
    in_valid = 1'b0; in_kind = 2'd0; in_size = 2'd0; in_addr = 64'd0; in_wdata = 64'd0; in_tag = 32'd0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #3;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_load_buffer", load_buffer, 64'd0);
    checkOutput("rst_lb_done", 64'(loadbuffer_done), 64'd0);
    checkOutput("rst_active", 64'(memstage_active), 64'd0);
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_req_addr", mem_req_addr, 64'd0);
    checkOutput("rst_req_wmask", 64'(mem_req_wmask), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] aligned load 0x1000");
    pushReq(1'b0, 64'h1000, 64'd0, 8'h00);
    respQ.push_back(64'h1122_3344_5566_7788);
    pushOut(32'h101, 1'b1, 1'b0, 64'h1122_3344_5566_7788);
    applyStimulus(2'd1, 2'd3, 64'h1000, 64'd0, 32'h101);
    checkOutput("ld_lat_c1", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("ld_lat_c3", 64'(out_valid), 64'd1);
    waitDrain("aligned_load");

    $display("[TB] split load 0x1006 size 2");
    pushReq(1'b0, 64'h1000, 64'd0, 8'h00);
    pushReq(1'b0, 64'h1008, 64'd0, 8'h00);
    respQ.push_back(64'hBBAA_0000_1234_5678);
    respQ.push_back(64'h9999_8888_7777_DDCC);
    pushOut(32'h102, 1'b1, 1'b0, 64'h0000_0000_DDCC_BBAA);
    applyStimulus(2'd1, 2'd2, 64'h1006, 64'd0, 32'h102);
    waitDrain("split_load");

    $display("[TB] split store 0x2007 size 1");
    pushReq(1'b1, 64'h2000, 64'hAA00_0000_0000_0000, 8'h80);
    pushReq(1'b1, 64'h2008, 64'h0000_0000_0000_0055, 8'h01);
    respQ.push_back(64'd0);
    respQ.push_back(64'd0);
    pushOut(32'h103, 1'b0, 1'b1, 64'd0);
    applyStimulus(2'd2, 2'd1, 64'h2007, 64'h0000_0000_0000_55AA, 32'h103);
    waitDrain("split_store");

    $display("[TB] pass-through kinds 0 and 3");
    pushOut(32'hCAFE, 1'b0, 1'b0, 64'd0);
    applyStimulus(2'd0, 2'd3, 64'h4000, 64'd0, 32'hCAFE);
    checkOutput("pt_latency", 64'(out_valid), 64'd1);
    waitDrain("pass0");
    pushOut(32'hBEEF, 1'b0, 1'b0, 64'd0);
    applyStimulus(2'd3, 2'd0, 64'h4001, 64'd0, 32'hBEEF);
    checkOutput("pt3_latency", 64'(out_valid), 64'd1);
    waitDrain("pass3");

    $display("[TB] unsplit offset loads");
    pushReq(1'b0, 64'h1000, 64'd0, 8'h00);
    respQ.push_back(64'h0011_2233_4455_6677);
    pushOut(32'h106, 1'b1, 1'b0, 64'h0000_0000_0000_1122);
    applyStimulus(2'd1, 2'd1, 64'h1005, 64'd0, 32'h106);
    waitDrain("load_off5");
    pushReq(1'b0, 64'h1000, 64'd0, 8'h00);
    respQ.push_back(64'h0011_2233_4455_6677);
    pushOut(32'h107, 1'b1, 1'b0, 64'h0000_0000_0011_2233);
    applyStimulus(2'd1, 2'd2, 64'h1004, 64'd0, 32'h107);
    waitDrain("load_edge8");

    $display("[TB] split 8-byte load 0x1003");
    pushReq(1'b0, 64'h1000, 64'd0, 8'h00);
    pushReq(1'b0, 64'h1008, 64'd0, 8'h00);
    respQ.push_back(64'h0706_0504_0302_0100);
    respQ.push_back(64'h0F0E_0D0C_0B0A_0908);
    pushOut(32'h108, 1'b1, 1'b0, 64'h0A09_0807_0605_0403);
    applyStimulus(2'd1, 2'd3, 64'h1003, 64'd0, 32'h108);
    waitDrain("split_load8");

    $display("[TB] offset byte store 0x2003");
    pushReq(1'b1, 64'h2000, 64'h0000_0000_5A00_0000, 8'h08);
    respQ.push_back(64'd0);
    pushOut(32'h10A, 1'b0, 1'b1, 64'd0);
    applyStimulus(2'd2, 2'd0, 64'h2003, 64'hFFFF_FFFF_FFFF_FF5A, 32'h10A);
    waitDrain("byte_store");

    $display("[TB] backpressure on bus and output");
    memStall = 3;
    outStall = 2;
    pushReq(1'b1, 64'h1010, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    respQ.push_back(64'd0);
    pushOut(32'h109, 1'b0, 1'b1, 64'd0);
    applyStimulus(2'd2, 2'd2, 64'h1010, 64'hFFFF_FFFF_DEAD_BEEF, 32'h109);
    w = 0;
    forever begin
      @(negedge clk);
      #1;
      if ((out_valid && out_ready) || w >= 40) break;
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      w++;
    end
    if (w >= 40) begin
      checks++; errors++;
      $display("[TB] FAIL bp_timeout actual=no_handshake required=handshake");
    end
    @(negedge clk);
    #1;
    checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);
    waitDrain("backpressure");

    $display("[TB] reset during WAIT0");
    hsBefore = reqHandshakes;
    pushReq(1'b0, 64'h1100, 64'd0, 8'h00);
    pushOut(32'h077, 1'b1, 1'b0, 64'd0);
    applyStimulus(2'd1, 2'd3, 64'h1100, 64'd0, 32'h077);
    w = 0;
    #1;
    while (reqHandshakes == hsBefore && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL rst_req_timeout actual=no_request required=request");
    end
    @(negedge clk);
    #1;
    checkOutput("rst_pre_active", 64'(memstage_active), 64'd1);
    reset_n = 1'b0;
    expOut.delete();
    #1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_active", 64'(memstage_active), 64'd0);
    checkOutput("abort_load_buffer", load_buffer, 64'd0);
    checkOutput("abort_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    injectResp = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stray_resp_active", 64'(memstage_active), 64'd0);
    checkOutput("stray_resp_out_valid", 64'(out_valid), 64'd0);
    checkOutput("stray_resp_load_buffer", load_buffer, 64'd0);

    $display("[TB] store then reload 0x3000");
    pushReq(1'b1, 64'h3000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    respQ.push_back(64'd0);
    pushOut(32'h130, 1'b0, 1'b1, 64'd0);
    applyStimulus(2'd2, 2'd3, 64'h3000, 64'h0123_4567_89AB_CDEF, 32'h130);
    waitDrain("fwd_store");
`ifdef MEMSTAGE_STLD_FWD_EN
    pushOut(32'h131, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    applyStimulus(2'd1, 2'd3, 64'h3000, 64'd0, 32'h131);
    checkOutput("fwd_latency", 64'(out_valid), 64'd1);
`else
    pushReq(1'b0, 64'h3000, 64'd0, 8'h00);
    respQ.push_back(64'h0123_4567_89AB_CDEF);
    pushOut(32'h131, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    applyStimulus(2'd1, 2'd3, 64'h3000, 64'd0, 32'h131);
`endif
    waitDrain("fwd_load");

    repeat (3) @(negedge clk);
    checkOutput("final_out_queue", 64'(expOut.size()), 64'd0);
    checkOutput("final_req_queue", 64'(expReq.size()), 64'd0);
    checkOutput("final_resp_queue", 64'(respQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
